// File: rtl/hpm_counter_bank_pkg.sv
// Shared constants for the programmable performance-counter bank.
// Holds CSR base addresses, mhpmevent flag bit positions (in the 64-bit
// view; XLEN=32 sees bits 63:60 as mhpmeventh[31:28]), privilege encodings,
// the per-counter write-strobe payload and a CSR address match helper.
package hpm_counter_bank_pkg;

  localparam logic [11:0] MHPMCOUNTER_BASE  = 12'hB03;
  localparam logic [11:0] MHPMCOUNTERH_BASE = 12'hB83;
  localparam logic [11:0] MHPMEVENT_BASE    = 12'h323;
  localparam logic [11:0] MHPMEVENTH_BASE   = 12'h723;
  localparam logic [11:0] HPMCOUNTER_BASE   = 12'hC03;
  localparam logic [11:0] HPMCOUNTERH_BASE  = 12'hC83;

  localparam int unsigned OF_BIT   = 63;
  localparam int unsigned MINH_BIT = 62;
  localparam int unsigned SINH_BIT = 61;
  localparam int unsigned UINH_BIT = 60;

  localparam logic [1:0] PRIV_M = 2'd3;
  localparam logic [1:0] PRIV_S = 2'd1;
  localparam logic [1:0] PRIV_U = 2'd0;

  // Write strobes steered to one counter slice
  typedef struct packed {
    logic cntLo;
    logic cntHi;
    logic evtLo;
    logic evtHi;
  } hpmWrite_t;

  // True when adr addresses entry idx of the register array starting at base
  function automatic logic csrMatch(input logic [11:0] adr, input logic [11:0] base,
                                    input int unsigned idx);
    return adr == (base + 12'(idx));
  endfunction

endpackage

// File: rtl/hpm_counter_slice.sv
// One programmable performance counter with its mhpmevent register.
// Optional feature macro: HPM_MODE_FILTER_EN (MINH/SINH/UINH privilege filter).
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   eventVec          event strobes; selector value k+1 picks bit k
//   privilegeMode     current privilege mode (used only with the mode filter)
//   inhibit           mcountinhibit bit for this counter
//   wr                write strobes for counter lo/hi and event lo/hi
//   writeVal          CSR write data
//   cntView           counter zero-extended to 64 bits
//   evtView           mhpmevent in its 64-bit layout
//   ovfEvent_c        increment wrapped the counter this cycle
module hpm_counter_slice
  import hpm_counter_bank_pkg::*;
#(
  parameter int unsigned XLEN       = 64,
  parameter int unsigned NUM_EVENTS = 32,
  parameter int unsigned EVSEL_W    = 8,
  parameter int unsigned CNT_W      = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_EVENTS-1:0] eventVec,
  input  logic [1:0]            privilegeMode,
  input  logic                  inhibit,
  input  hpmWrite_t             wr,
  input  logic [XLEN-1:0]       writeVal,
  output logic [63:0]           cntView,
  output logic [63:0]           evtView,
  output logic                  ovfEvent_c
);

  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   cntInc;
  logic [EVSEL_W-1:0] sel;
  logic               ofBit;
  logic               minh;
  logic               sinh;
  logic               uinh;
  logic               evtHit;
  logic               modeBlock;
  logic               incEn;
  logic               cntWritten;
  logic [63:0]        cntMerge;
  logic [63:0]        evtMerge;
  logic               unusedEvtBits;

  // Event select: selector k+1 picks bit k, anything else counts nothing
  always_comb begin
    evtHit = 1'b0;
    for (int k = 0; k < int'(NUM_EVENTS); k++) begin
      if (32'(sel) == 32'(k + 1)) evtHit = eventVec[k];
    end
  end

`ifdef HPM_MODE_FILTER_EN
  // Mode inhibit bits, written from the merged event write value
  always_ff @(posedge clk) begin
    if (reset) begin
      minh <= 1'b0;
      sinh <= 1'b0;
      uinh <= 1'b0;
    end else begin
      minh <= evtMerge[MINH_BIT];
      sinh <= evtMerge[SINH_BIT];
      uinh <= evtMerge[UINH_BIT];
    end
  end

  assign modeBlock = (minh && (privilegeMode == PRIV_M)) ||
                     (sinh && (privilegeMode == PRIV_S)) ||
                     (uinh && (privilegeMode == PRIV_U));
`else
  logic unusedPriv;
  assign unusedPriv = ^privilegeMode;
  assign minh       = 1'b0;
  assign sinh       = 1'b0;
  assign uinh       = 1'b0;
  assign modeBlock  = 1'b0;
`endif

  assign incEn      = evtHit && !inhibit && !modeBlock;
  assign cntInc     = cnt + CNT_W'(1);
  assign cntWritten = wr.cntLo || wr.cntHi;
  // A CSR write to either half suppresses overflow reporting
  assign ovfEvent_c = incEn && (cnt == '1) && !cntWritten;

  // Counter write merge: written half replaces the advanced value's half
  always_comb begin
    cntMerge = 64'(incEn ? cntInc : cnt);
    if (wr.cntLo) cntMerge[XLEN-1:0] = writeVal;
    if (wr.cntHi) cntMerge[63:32]    = writeVal[31:0];
  end

  // Event write merge on top of the current state with any new overflow,
  // so a write that covers OF overrides a same-cycle overflow
  always_comb begin
    evtMerge                = '0;
    evtMerge[EVSEL_W-1:0]   = sel;
    evtMerge[OF_BIT]        = ofBit || ovfEvent_c;
    evtMerge[MINH_BIT]      = minh;
    evtMerge[SINH_BIT]      = sinh;
    evtMerge[UINH_BIT]      = uinh;
    if (wr.evtLo) evtMerge[XLEN-1:0] = writeVal;
    if (wr.evtHi) evtMerge[63:32]    = writeVal[31:0];
  end

  assign unusedEvtBits = ^evtMerge;

  // Counter, selector and overflow state
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt   <= '0;
      sel   <= '0;
      ofBit <= 1'b0;
    end else begin
      cnt   <= CNT_W'(cntMerge);
      sel   <= evtMerge[EVSEL_W-1:0];
      ofBit <= evtMerge[OF_BIT];
    end
  end

  // Read views in the 64-bit register layout
  always_comb begin
    cntView               = 64'(cnt);
    evtView               = '0;
    evtView[EVSEL_W-1:0]  = sel;
    evtView[OF_BIT]       = ofBit;
    evtView[MINH_BIT]     = minh;
    evtView[SINH_BIT]     = sinh;
    evtView[UINH_BIT]     = uinh;
  end

endmodule

// File: rtl/hpm_counter_bank.sv
// Bank of NUM_CNT programmable performance counters (mhpmcounter3 upward)
// with per-counter event select, sticky overflow and an overflow interrupt.
// Optional feature macro: HPM_MODE_FILTER_EN (handled inside each slice).
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   EventVecM           one-cycle event strobes
//   PrivilegeModeW      current privilege mode
//   MCOUNTINHIBIT_REGW  bit j+3 inhibits counter j
//   CSRMWriteM          machine CSR write strobe
//   CSRAdrM             CSR address
//   CSRWriteValM        CSR write data
//   ClearLcofM          clears the overflow-pending flag
//   CSRHitM             address hits this bank (combinational)
//   CSRReadValM         read data, 0 on miss (combinational)
//   LcofPendM           local counter-overflow interrupt pending
module hpm_counter_bank
  import hpm_counter_bank_pkg::*;
#(
  parameter int unsigned XLEN       = 64,
  parameter int unsigned NUM_CNT    = 8,
  parameter int unsigned NUM_EVENTS = 32,
  parameter int unsigned EVSEL_W    = 8,
  parameter int unsigned CNT_W      = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_EVENTS-1:0] EventVecM,
  input  logic [1:0]            PrivilegeModeW,
  input  logic [31:0]           MCOUNTINHIBIT_REGW,
  input  logic                  CSRMWriteM,
  input  logic [11:0]           CSRAdrM,
  input  logic [XLEN-1:0]       CSRWriteValM,
  input  logic                  ClearLcofM,
  output logic                  CSRHitM,
  output logic [XLEN-1:0]       CSRReadValM,
  output logic                  LcofPendM
);

  localparam bit HAS_HI = (XLEN == 32);

  logic [NUM_CNT-1:0] ovf;
  logic [NUM_CNT-1:0] hitVec;
  logic [XLEN-1:0]    readVec [NUM_CNT];
  logic               unusedInhibit;

  assign unusedInhibit = ^MCOUNTINHIBIT_REGW;

  for (genvar j = 0; j < int'(NUM_CNT); j++) begin : gSlice
    logic        aCnt;
    logic        aCntH;
    logic        aEvt;
    logic        aEvtH;
    logic        aUsr;
    logic        aUsrH;
    hpmWrite_t   wr;
    logic [63:0] cntView;
    logic [63:0] evtView;

    // Address decode for counter j; user shadows are read-only
    assign aCnt  = csrMatch(CSRAdrM, MHPMCOUNTER_BASE, j);
    assign aEvt  = csrMatch(CSRAdrM, MHPMEVENT_BASE, j);
    assign aUsr  = csrMatch(CSRAdrM, HPMCOUNTER_BASE, j);
    assign aCntH = HAS_HI && csrMatch(CSRAdrM, MHPMCOUNTERH_BASE, j);
    assign aEvtH = HAS_HI && csrMatch(CSRAdrM, MHPMEVENTH_BASE, j);
    assign aUsrH = HAS_HI && csrMatch(CSRAdrM, HPMCOUNTERH_BASE, j);

    assign wr.cntLo = CSRMWriteM && aCnt;
    assign wr.cntHi = CSRMWriteM && aCntH;
    assign wr.evtLo = CSRMWriteM && aEvt;
    assign wr.evtHi = CSRMWriteM && aEvtH;

    assign hitVec[j] = aCnt || aCntH || aEvt || aEvtH || aUsr || aUsrH;

    assign readVec[j] = ({XLEN{aCnt || aUsr}}   & cntView[XLEN-1:0])
                      | ({XLEN{aCntH || aUsrH}} & XLEN'(cntView[63:32]))
                      | ({XLEN{aEvt}}           & evtView[XLEN-1:0])
                      | ({XLEN{aEvtH}}          & XLEN'(evtView[63:32]));

    hpm_counter_slice #(
      .XLEN       (XLEN),
      .NUM_EVENTS (NUM_EVENTS),
      .EVSEL_W    (EVSEL_W),
      .CNT_W      (CNT_W)
    ) uSlice (
      .clk           (clk),
      .reset         (reset),
      .eventVec      (EventVecM),
      .privilegeMode (PrivilegeModeW),
      .inhibit       (MCOUNTINHIBIT_REGW[j+3]),
      .wr            (wr),
      .writeVal      (CSRWriteValM),
      .cntView       (cntView),
      .evtView       (evtView),
      .ovfEvent_c    (ovf[j])
    );
  end

  // Read mux: only the hit slice contributes non-zero data
  always_comb begin
    CSRReadValM = '0;
    for (int j = 0; j < int'(NUM_CNT); j++) begin
      CSRReadValM = CSRReadValM | readVec[j];
    end
  end

  assign CSRHitM = |hitVec;

  // Overflow interrupt pending; a new overflow beats a same-cycle clear
  always_ff @(posedge clk) begin
    if (reset)           LcofPendM <= 1'b0;
    else if (|ovf)       LcofPendM <= 1'b1;
    else if (ClearLcofM) LcofPendM <= 1'b0;
  end

endmodule
